wb_arbiter2: RTL and testbench

//  Two-master, one-slave Wishbone arbiter sharing the single external bus between the data-side
//  (m0) and instruction-side (m1) wishbone_bus_if instances of the CPU. Grants one master at a

---
 rtl/wb_arbiter2_pkg.sv | 15 +
 rtl/wb_arbiter2_timer.sv | 37 +++
 rtl/wb_arbiter2.sv | 175 +++++++++++++++++
 tb/tb_wb_arbiter2.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter2_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM state encoding and master ids.
// The encodings match the WB_ARB_* values used elsewhere in the CPU codebase.
package wb_arbiter2_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_GNT0  = 2'b01,
        ARB_GNT1  = 2'b10,
        ARB_ABORT = 2'b11
    } arb_state_e;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

endpackage

// File: rtl/wb_arbiter2_timer.sv
// Stall watchdog for the arbiter: counts stb cycles without ack and flags expiry.
// Only instantiated when WB_ARB_TIMEOUT_EN is defined.
module wb_arb_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == CNT_W'(TIMEOUT_CYC));

    // Saturate at the limit; the arbiter leaves the grant state on expiry and clears us.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master / one-slave Wishbone arbiter (m0 = data side, m1 = instruction side).
// Optional stall timeout with abort is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter2
    import wb_arbiter2_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int SEL_W       = 4,
    parameter int FIXED_PRIO  = 0,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [SEL_W-1:0]  m0_sel_i,
    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic [DATA_W-1:0] m0_dat_i,
    output logic [DATA_W-1:0] m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [SEL_W-1:0]  m1_sel_i,
    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    output logic [DATA_W-1:0] m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [SEL_W-1:0]  s_sel_o,
    output logic [ADDR_W-1:0] s_adr_o,
    output logic [DATA_W-1:0] s_dat_o,
    input  logic [DATA_W-1:0] s_dat_i,
    input  logic              s_ack_i,
    output logic [1:0]        gnt_o,
    output arb_state_e        state_o
);

    // Handshake: a master owns the bus from grant until its cyc_i falls; each beat is
    // stb_i held until ack_o, which is s_ack_i qualified by the owner's stb_i.

    arb_state_e state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic       last_q, last_d;
    logic       expired;

    assign gnt_o    = gnt_q;
    assign state_o  = state_q;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
    logic tmr_clr, tmr_inc;

    assign tmr_inc = ((state_q == ARB_GNT0) && m0_stb_i ||
                      (state_q == ARB_GNT1) && m1_stb_i) && !s_ack_i;
    assign tmr_clr = s_ack_i || (state_d != state_q);

    wb_arb_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (tmr_clr),
        .inc_i     (tmr_inc),
        .expired_o (expired)
    );
`else
    logic unused_tmo;

    assign expired    = 1'b0;
    assign unused_tmo = ^TIMEOUT_CYC;
`endif

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = 2'b00;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = (FIXED_PRIO != 0 || last_q == ARB_M1) ? ARB_GNT0 : ARB_GNT1;
                end else if (m0_cyc_i) begin
                    state_d = ARB_GNT0;
                end else if (m1_cyc_i) begin
                    state_d = ARB_GNT1;
                end
            end
            ARB_GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i & m0_stb_i;
                if (expired) begin
                    s_cyc_o  = 1'b0;
                    s_stb_o  = 1'b0;
                    m0_ack_o = 1'b0;
                    m0_err_o = 1'b1;
                    state_d  = ARB_ABORT;
                end else if (!m0_cyc_i) begin
                    last_d  = ARB_M0;
                    state_d = m1_cyc_i ? ARB_GNT1 : ARB_IDLE;
                end
            end
            ARB_GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i & m1_stb_i;
                if (expired) begin
                    s_cyc_o  = 1'b0;
                    s_stb_o  = 1'b0;
                    m1_ack_o = 1'b0;
                    m1_err_o = 1'b1;
                    state_d  = ARB_ABORT;
                end else if (!m1_cyc_i) begin
                    last_d  = ARB_M1;
                    state_d = m0_cyc_i ? ARB_GNT0 : ARB_IDLE;
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            // The aborted master keeps ownership (gnt_q) until it drops cyc_i.
            ARB_ABORT: begin
                if (!(gnt_q[1] ? m1_cyc_i : m0_cyc_i)) begin
                    last_d  = gnt_q[1] ? ARB_M1 : ARB_M0;
                    state_d = ARB_IDLE;
                end
            end
`endif
            default: state_d = ARB_IDLE;
        endcase

        case (state_d)
            ARB_GNT0:  gnt_d = 2'b01;
            ARB_GNT1:  gnt_d = 2'b10;
            ARB_ABORT: gnt_d = gnt_q;
            default:   gnt_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            gnt_q   <= 2'b00;
            last_q  <= ARB_M1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 (round-robin build); the timeout scenario runs
// when WB_ARB_TIMEOUT_EN is defined, otherwise an indefinite-hold scenario runs.
module tb_wb_arbiter2;
    import wb_arbiter2_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [SW-1:0] m0_sel_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i, m0_dat_o;
    logic          m0_ack_o, m0_err_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [SW-1:0] m1_sel_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i, m1_dat_o;
    logic          m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [SW-1:0] s_sel_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o, s_dat_i;
    logic          s_ack_i;
    logic [1:0]    gnt_o;
    arb_state_e    state_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_arbiter2 #(
        .ADDR_W (AW), .DATA_W (DW), .SEL_W (SW), .FIXED_PRIO (0), .TIMEOUT_CYC (8)
    ) dut (
        .clk (clk), .rst (rst),
        .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i), .m0_we_i (m0_we_i),
        .m0_sel_i (m0_sel_i), .m0_adr_i (m0_adr_i), .m0_dat_i (m0_dat_i),
        .m0_dat_o (m0_dat_o), .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o),
        .m1_cyc_i (m1_cyc_i), .m1_stb_i (m1_stb_i), .m1_we_i (m1_we_i),
        .m1_sel_i (m1_sel_i), .m1_adr_i (m1_adr_i), .m1_dat_i (m1_dat_i),
        .m1_dat_o (m1_dat_o), .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o),
        .s_cyc_o (s_cyc_o), .s_stb_o (s_stb_o), .s_we_o (s_we_o),
        .s_sel_o (s_sel_o), .s_adr_o (s_adr_o), .s_dat_o (s_dat_o),
        .s_dat_i (s_dat_i), .s_ack_i (s_ack_i),
        .gnt_o (gnt_o), .state_o (state_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive just after the active edge; sample on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic masters_idle();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = '0; m0_adr_i = '0; m0_dat_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = '0; m1_adr_i = '0; m1_dat_i = '0;
    endtask

    task automatic req(input int m, input logic on);
        if (m == 0) begin m0_cyc_i = on; m0_stb_i = on; end
        else begin m1_cyc_i = on; m1_stb_i = on; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        rst = 1'b1;
        s_ack_i = 1'b0;
        s_dat_i = '0;
        masters_idle();
        tick();
        tick();
        settle();
        check_eq("rst_gnt", gnt_o, 2'b00);
        check_eq("rst_state", state_o, ARB_IDLE);
        check_eq("rst_s_cyc", s_cyc_o, 1'b0);
        check_eq("rst_acks", {m1_ack_o, m0_ack_o, m1_err_o, m0_err_o}, 4'b0000);
        tick();
        rst = 1'b0;

        // Stray slave ack with nobody granted
        s_ack_i = 1'b1;
        s_dat_i = 32'hAAAA_5555;
        settle();
        check_eq("stray_acks", {m1_ack_o, m0_ack_o}, 2'b00);
        check_eq("stray_s_cyc", s_cyc_o, 1'b0);
        tick();
        s_ack_i = 1'b0;
        settle();
        check_eq("stray_state", state_o, ARB_IDLE);
        check_eq("stray_gnt", gnt_o, 2'b00);

        // Tie from reset: m0 first, then direct handover to m1
        tick();
        m0_adr_i = 32'h0000_0AA0;
        m1_adr_i = 32'h0000_0BB0;
        req(0, 1); req(1, 1);
        settle();
        check_eq("tie1_latency", gnt_o, 2'b00);
        tick();
        settle();
        check_eq("tie1_first", gnt_o, 2'b01);
        check_eq("tie1_adr_m0", s_adr_o, 32'h0000_0AA0);
        tick();
        req(0, 0);
        tick();
        settle();
        check_eq("tie1_handover", gnt_o, 2'b10);
        check_eq("tie1_state", state_o, ARB_GNT1);
        check_eq("tie1_adr_m1", s_adr_o, 32'h0000_0BB0);
        tick();
        req(1, 0);
        tick();
        settle();
        check_eq("tie1_release", gnt_o, 2'b00);

        // Single m0 read, slave acks two cycles after stb
        tick();
        masters_idle();
        m0_adr_i = 32'h0000_0100;
        m0_sel_i = 4'hF;
        req(0, 1);
        settle();
        check_eq("rd_latency", gnt_o, 2'b00);
        tick();
        settle();
        check_eq("rd_gnt", gnt_o, 2'b01);
        check_eq("rd_s_adr", s_adr_o, 32'h0000_0100);
        check_eq("rd_s_cyc_stb_we", {s_cyc_o, s_stb_o, s_we_o}, 3'b110);
        check_eq("rd_no_early_ack", m0_ack_o, 1'b0);
        tick();
        s_ack_i = 1'b1;
        s_dat_i = 32'hDEAD_BEEF;
        settle();
        check_eq("rd_m0_ack", m0_ack_o, 1'b1);
        check_eq("rd_m0_dat", m0_dat_o, 32'hDEAD_BEEF);
        check_eq("rd_m1_ack", m1_ack_o, 1'b0);
        tick();
        s_ack_i = 1'b0;
        req(0, 0);
        settle();
        check_eq("rd_s_cyc_follow", s_cyc_o, 1'b0);
        tick();
        settle();
        check_eq("rd_release", gnt_o, 2'b00);

        // Second tie after m0 was served last: m1 first, then m0
        tick();
        req(0, 1); req(1, 1);
        tick();
        settle();
        check_eq("tie2_first", gnt_o, 2'b10);
        tick();
        req(1, 0);
        tick();
        settle();
        check_eq("tie2_handover", gnt_o, 2'b01);
        tick();
        req(0, 0);
        tick();
        settle();
        check_eq("tie2_release", gnt_o, 2'b00);

        // m1 write while m0 idle (m0 fields non-zero to expose a wrong mux select)
        tick();
        masters_idle();
        m0_adr_i = 32'hFFFF_0000; m0_dat_i = 32'hCAFE_F00D; m0_sel_i = 4'b1100;
        m1_adr_i = 32'h0000_0010; m1_dat_i = 32'h1234_5678; m1_sel_i = 4'b0011; m1_we_i = 1'b1;
        req(1, 1);
        tick();
        settle();
        check_eq("wr_gnt", gnt_o, 2'b10);
        check_eq("wr_s_adr", s_adr_o, 32'h0000_0010);
        check_eq("wr_s_dat", s_dat_o, 32'h1234_5678);
        check_eq("wr_s_sel", s_sel_o, 4'b0011);
        check_eq("wr_s_we_cyc_stb", {s_we_o, s_cyc_o, s_stb_o}, 3'b111);
        tick();
        s_ack_i = 1'b1;
        settle();
        check_eq("wr_acks", {m1_ack_o, m0_ack_o}, 2'b10);
        tick();
        s_ack_i = 1'b0;
        req(1, 0);
        tick();
        settle();
        check_eq("wr_release_gnt", gnt_o, 2'b00);
        check_eq("wr_release_s_bus", {s_adr_o, s_dat_o}, 64'h0);
        check_eq("wr_release_s_ctl", {s_sel_o, s_we_o, s_cyc_o, s_stb_o}, 7'h0);

        // Reset while m1 holds the bus with stb pending; afterwards a tie goes to m0
        tick();
        req(1, 1);
        tick();
        settle();
        check_eq("rstx_pre_gnt", gnt_o, 2'b10);
        tick();
        rst = 1'b1;
        tick();
        settle();
        check_eq("rstx_s_cyc", s_cyc_o, 1'b0);
        check_eq("rstx_gnt", gnt_o, 2'b00);
        check_eq("rstx_state", state_o, ARB_IDLE);
        masters_idle();
        tick();
        rst = 1'b0;
        req(0, 1); req(1, 1);
        tick();
        settle();
        check_eq("rstx_tie", gnt_o, 2'b01);
        tick();
        masters_idle();
        tick();
        tick();
        settle();
        check_eq("rstx_idle", gnt_o, 2'b00);

`ifdef WB_ARB_TIMEOUT_EN
        // Slave never acks m0: error after 8 stalled stb cycles, m1 waits for m0 to let go
        do_reset();
        req(0, 1);
        tick();
        settle();
        check_eq("tmo_gnt", gnt_o, 2'b01);
        m1_cyc_i = 1'b1;
        m1_stb_i = 1'b1;
        n = 0;
        while (!m0_err_o && n < 20) begin
            n++;
            settle();
        end
        check_eq("tmo_err_seen", m0_err_o, 1'b1);
        check_eq("tmo_stall_cycles", n, 8);
        check_eq("tmo_s_cyc_stb", {s_cyc_o, s_stb_o}, 2'b00);
        check_eq("tmo_m1_err", m1_err_o, 1'b0);
        settle();
        check_eq("tmo_state_abort", state_o, ARB_ABORT);
        check_eq("tmo_err_pulse", m0_err_o, 1'b0);
        check_eq("tmo_abort_s_cyc", s_cyc_o, 1'b0);
        settle();
        settle();
        check_eq("tmo_m1_blocked", gnt_o[1], 1'b0);
        tick();
        req(0, 0);
        tick();
        settle();
        check_eq("tmo_idle", state_o, ARB_IDLE);
        tick();
        settle();
        check_eq("tmo_m1_gnt", gnt_o, 2'b10);
        tick();
        masters_idle();
        tick();
`else
        // No timeout: the grant is held as long as the master keeps cyc_i high
        do_reset();
        req(0, 1);
        for (int i = 0; i < 20; i++) tick();
        settle();
        check_eq("hold_gnt", gnt_o, 2'b01);
        check_eq("hold_s_cyc", s_cyc_o, 1'b1);
        check_eq("hold_err", {m1_err_o, m0_err_o}, 2'b00);
        tick();
        masters_idle();
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
